// File: rtl/aia_csr_bridge_pkg.sv
// Shared types for the AIA CSR bridge: FSM states, privilege encodings and
// the queued request record.
package aia_csr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PRIV_U  = 2'b00,
    PRIV_S  = 2'b01,
    PRIV_VS = 2'b10,
    PRIV_M  = 2'b11
  } priv_e;

  // Fields are stored at their widest supported size so one record type can
  // serve every bridge configuration (up to 256 harts, 255 VS files, XLEN 64).
  localparam int REQ_HART_W  = 8;
  localparam int REQ_VGEIN_W = 8;
  localparam int REQ_DATA_W  = 64;

  typedef struct packed {
    logic [REQ_HART_W-1:0]  hart;
    priv_e                  priv;
    logic [REQ_VGEIN_W-1:0] vgein;
    logic [31:0]            addr;
    logic [REQ_DATA_W-1:0]  data;
    logic                   we;
    logic                   claim;
  } req_t;

endpackage

// File: rtl/aia_csr_fifo.sv
// Power-of-two depth request queue; the head entry is visible on dout while
// the queue is non-empty.
module aia_csr_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aia_csr_bridge.sv
// Serialises CSR requests from a shared queue onto per-hart IMSIC ports and
// returns one response per request, in order.
module aia_csr_bridge
  import aia_csr_bridge_pkg::*;
#(
  parameter int  NR_IMSICS             = 4,
  parameter int  NR_VS_FILES_PER_IMSIC = 1,
  parameter int  XLEN                  = 64,
  parameter int  NR_SRC_IMSIC          = 64,
  parameter int  FIFO_DEPTH            = 4,
  localparam int TW                    = $clog2(NR_SRC_IMSIC),
  localparam int NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  localparam int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
  localparam int HW                    = ($clog2(NR_IMSICS) > 1) ? $clog2(NR_IMSICS) : 1
) (
  input  logic                        i_clk,
  input  logic                        ni_rst,
  // Request and response channels: a transfer happens on the rising edge where
  // valid && ready; the sender holds its payload stable until that edge.
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [HW-1:0]               i_req_hart,
  input  logic [1:0]                  i_req_priv,
  input  logic [VS_INTP_FILE_LEN:0]   i_req_vgein,
  input  logic [31:0]                 i_req_addr,
  input  logic [XLEN-1:0]             i_req_data,
  input  logic                        i_req_we,
  input  logic                        i_req_claim,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [XLEN-1:0]             o_rsp_data,
  output logic [TW-1:0]               o_rsp_topei,
  output logic                        o_rsp_error,
  output logic [1:0]                  o_priv_lvl    [NR_IMSICS],
  output logic [VS_INTP_FILE_LEN:0]   o_vgein       [NR_IMSICS],
  output logic [31:0]                 o_imsic_addr  [NR_IMSICS],
  output logic [XLEN-1:0]             o_imsic_data  [NR_IMSICS],
  output logic                        o_imsic_we    [NR_IMSICS],
  output logic                        o_imsic_claim [NR_IMSICS],
  input  logic [XLEN-1:0]             i_imsic_data      [NR_IMSICS],
  input  logic                        i_imsic_exception [NR_IMSICS],
  input  logic [TW-1:0]               i_xtopei          [NR_IMSICS][NR_INTP_FILES],
  output logic [1:0]                  o_dbg_state
);

  localparam int FW = $clog2(NR_INTP_FILES);

  state_e        state;
  req_t          req_in;
  req_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          head_illegal;
  logic [FW-1:0] head_file;
  logic [HW-1:0] cur_hart;
  logic [FW-1:0] cur_file;

  always_comb begin
    req_in       = '0;
    req_in.hart  = REQ_HART_W'(i_req_hart);
    req_in.priv  = priv_e'(i_req_priv);
    req_in.vgein = REQ_VGEIN_W'(i_req_vgein);
    req_in.addr  = i_req_addr;
    req_in.data  = REQ_DATA_W'(i_req_data);
    req_in.we    = i_req_we;
    req_in.claim = i_req_claim;
  end

  assign o_req_ready = !fifo_full;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign o_dbg_state = state;

  aia_csr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (ni_rst),
    .push  (i_req_valid && o_req_ready),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_illegal = 1'b0;
    if (int'(head.hart) >= NR_IMSICS) head_illegal = 1'b1;
    if (head.priv == PRIV_U) head_illegal = 1'b1;
    if (head.priv == PRIV_VS &&
        (head.vgein == '0 || int'(head.vgein) > NR_VS_FILES_PER_IMSIC)) head_illegal = 1'b1;
    if (head.we && head.claim) head_illegal = 1'b1;
  end

  // Interrupt file order inside an IMSIC: M, S, then the VS files.
  always_comb begin
    head_file = '0;
    case (head.priv)
      PRIV_S:  head_file = FW'(1);
      PRIV_VS: head_file = FW'(1 + int'(head.vgein));
      default: head_file = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state       <= ST_IDLE;
      cur_hart    <= '0;
      cur_file    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_topei <= '0;
      o_rsp_error <= 1'b0;
      for (int h = 0; h < NR_IMSICS; h++) begin
        o_priv_lvl[h]    <= '0;
        o_vgein[h]       <= '0;
        o_imsic_addr[h]  <= '0;
        o_imsic_data[h]  <= '0;
        o_imsic_we[h]    <= 1'b0;
        o_imsic_claim[h] <= 1'b0;
      end
    end else begin
      // IMSIC strobes live for a single cycle; only the IDLE pop re-arms them.
      for (int h = 0; h < NR_IMSICS; h++) begin
        o_priv_lvl[h]    <= '0;
        o_vgein[h]       <= '0;
        o_imsic_addr[h]  <= '0;
        o_imsic_data[h]  <= '0;
        o_imsic_we[h]    <= 1'b0;
        o_imsic_claim[h] <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_hart <= head.hart[HW-1:0];
            cur_file <= head_file;
            if (head_illegal) begin
              o_rsp_valid <= 1'b1;
              o_rsp_data  <= '0;
              o_rsp_topei <= '0;
              o_rsp_error <= 1'b1;
              state       <= ST_RESP;
            end else begin
              for (int h = 0; h < NR_IMSICS; h++) begin
                if (int'(head.hart) == h) begin
                  o_priv_lvl[h]    <= head.priv;
                  o_vgein[h]       <= head.vgein[VS_INTP_FILE_LEN:0];
                  o_imsic_addr[h]  <= head.addr;
                  o_imsic_data[h]  <= head.data[XLEN-1:0];
                  o_imsic_we[h]    <= head.we;
                  o_imsic_claim[h] <= head.claim;
                end
              end
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          o_rsp_valid <= 1'b1;
          o_rsp_data  <= i_imsic_data[cur_hart];
          o_rsp_topei <= i_xtopei[cur_hart][cur_file];
          o_rsp_error <= i_imsic_exception[cur_hart];
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aia_csr_bridge.sv
// Directed bench for aia_csr_bridge; five IMSICs so that a 3-bit hart field
// can express out-of-range indices.
module tb_aia_csr_bridge;

  localparam int NI = 5;
  localparam int NVS = 1;
  localparam int XL = 64;
  localparam int NSRC = 64;
  localparam int DEPTH = 4;
  localparam int TW = 6;
  localparam int NF = 3;
  localparam int HW = 3;
  localparam int VW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [HW-1:0] req_hart;
  logic [1:0]    req_priv;
  logic [VW-1:0] req_vgein;
  logic [31:0]   req_addr;
  logic [XL-1:0] req_data;
  logic          req_we;
  logic          req_claim;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [XL-1:0] rsp_data;
  logic [TW-1:0] rsp_topei;
  logic          rsp_error;
  logic [1:0]    priv_lvl    [NI];
  logic [VW-1:0] vgein       [NI];
  logic [31:0]   imsic_addr  [NI];
  logic [XL-1:0] imsic_wdata [NI];
  logic          imsic_we    [NI];
  logic          imsic_claim [NI];
  logic [XL-1:0] imsic_rdata [NI];
  logic          imsic_exc   [NI];
  logic [TW-1:0] xtopei      [NI][NF];
  logic [1:0]    dbg_state;

  int            tests = 0;
  int            fails = 0;
  logic [XL-1:0] exp_q [$];

  always #5 clk = ~clk;

  aia_csr_bridge #(
    .NR_IMSICS             (NI),
    .NR_VS_FILES_PER_IMSIC (NVS),
    .XLEN                  (XL),
    .NR_SRC_IMSIC          (NSRC),
    .FIFO_DEPTH            (DEPTH)
  ) dut (
    .i_clk             (clk),
    .ni_rst            (rst_n),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_hart        (req_hart),
    .i_req_priv        (req_priv),
    .i_req_vgein       (req_vgein),
    .i_req_addr        (req_addr),
    .i_req_data        (req_data),
    .i_req_we          (req_we),
    .i_req_claim       (req_claim),
    .o_rsp_valid       (rsp_valid),
    .i_rsp_ready       (rsp_ready),
    .o_rsp_data        (rsp_data),
    .o_rsp_topei       (rsp_topei),
    .o_rsp_error       (rsp_error),
    .o_priv_lvl        (priv_lvl),
    .o_vgein           (vgein),
    .o_imsic_addr      (imsic_addr),
    .o_imsic_data      (imsic_wdata),
    .o_imsic_we        (imsic_we),
    .o_imsic_claim     (imsic_claim),
    .i_imsic_data      (imsic_rdata),
    .i_imsic_exception (imsic_exc),
    .i_xtopei          (xtopei),
    .o_dbg_state       (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1);
  end

  function automatic logic [NI-1:0] active_mask();
    logic [NI-1:0] m;
    m = '0;
    for (int h = 0; h < NI; h++)
      m[h] = (|priv_lvl[h]) | (|vgein[h]) | (|imsic_addr[h]) | (|imsic_wdata[h]) |
             imsic_we[h] | imsic_claim[h];
    return m;
  endfunction

  // Driver: presents one request and returns one step after the accepting edge.
  task automatic send_req(input int hart, input logic [1:0] priv, input int vg,
                          input logic [31:0] addr, input logic [XL-1:0] data,
                          input logic we, input logic claim);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_hart  = HW'(hart);
    req_priv  = priv;
    req_vgein = VW'(vg);
    req_addr  = addr;
    req_data  = data;
    req_we    = we;
    req_claim = claim;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_req_ready: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Collector: steps until a response appears, noting IMSIC activity seen.
  task automatic wait_rsp(output int cycles, output logic [NI-1:0] seen, output int strobes);
    cycles  = 0;
    seen    = '0;
    strobes = 0;
    while (!rsp_valid && cycles < 20) begin
      seen = seen | active_mask();
      if (active_mask() != '0) strobes++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    tests++; if (active_mask() !== '0) begin fails++; $display("FAIL reset_imsic_zero: got %b required 0", active_mask()); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %0b required 1", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
    tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: got %0h required 0", rsp_data); end
    tests++; if (rsp_topei !== '0) begin fails++; $display("FAIL reset_rsp_topei: got %0d required 0", rsp_topei); end
    tests++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL reset_rsp_error: got %0b required 0", rsp_error); end
  endtask

  task automatic test_read_m();
    send_req(2, 2'b11, 0, 32'h70, '0, 1'b0, 1'b0);
    tests++; if (active_mask() !== 5'b00000) begin fails++; $display("FAIL read_e0_quiet: got %b required 00000", active_mask()); end
    @(posedge clk); #1;
    tests++; if (active_mask() !== 5'b00100) begin fails++; $display("FAIL read_strobe_mask: got %b required 00100", active_mask()); end
    tests++; if (imsic_addr[2] !== 32'h70) begin fails++; $display("FAIL read_addr: got %0h required 70", imsic_addr[2]); end
    tests++; if (priv_lvl[2] !== 2'b11) begin fails++; $display("FAIL read_priv: got %b required 11", priv_lvl[2]); end
    tests++; if (imsic_we[2] !== 1'b0) begin fails++; $display("FAIL read_we: got %0b required 0", imsic_we[2]); end
    @(posedge clk); #1;
    tests++; if (active_mask() !== 5'b00000) begin fails++; $display("FAIL read_strobe_once: got %b required 00000", active_mask()); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL read_rsp_early: got %0b required 0", rsp_valid); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL read_rsp_e3: got %0b required 1", rsp_valid); end
    tests++; if (rsp_data !== 64'hABCD) begin fails++; $display("FAIL read_rsp_data: got %0h required abcd", rsp_data); end
    tests++; if (rsp_topei !== 6'd5) begin fails++; $display("FAIL read_rsp_topei: got %0d required 5", rsp_topei); end
    tests++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL read_rsp_error: got %0b required 0", rsp_error); end
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hABCD) begin fails++; $display("FAIL read_rsp_hold: valid %0b data %0h required 1 abcd", rsp_valid, rsp_data); end
    ack_rsp();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL read_rsp_drop: got %0b required 0", rsp_valid); end
  endtask

  task automatic test_vs_claim();
    send_req(1, 2'b10, 1, 32'h70, '0, 1'b0, 1'b1);
    @(posedge clk); #1;
    tests++; if (active_mask() !== 5'b00010) begin fails++; $display("FAIL vs_strobe_mask: got %b required 00010", active_mask()); end
    tests++; if (imsic_claim[1] !== 1'b1) begin fails++; $display("FAIL vs_claim_high: got %0b required 1", imsic_claim[1]); end
    tests++; if (vgein[1] !== 1'b1 || priv_lvl[1] !== 2'b10) begin fails++; $display("FAIL vs_fields: vgein %0d priv %b required 1 10", vgein[1], priv_lvl[1]); end
    @(posedge clk); #1;
    tests++; if (imsic_claim[1] !== 1'b0) begin fails++; $display("FAIL vs_claim_once: got %0b required 0", imsic_claim[1]); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL vs_rsp_valid: got %0b required 1", rsp_valid); end
    tests++; if (rsp_topei !== 6'd7) begin fails++; $display("FAIL vs_rsp_topei: got %0d required 7", rsp_topei); end
    tests++; if (rsp_data !== 64'h101) begin fails++; $display("FAIL vs_rsp_data: got %0h required 101", rsp_data); end
    ack_rsp();
  endtask

  task automatic test_write_s();
    int            cyc;
    logic [NI-1:0] seen;
    int            strobes;
    send_req(3, 2'b01, 0, 32'h72, 64'h1234_5678_9abc_def0, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++; if (imsic_we[3] !== 1'b1) begin fails++; $display("FAIL write_we: got %0b required 1", imsic_we[3]); end
    tests++; if (imsic_wdata[3] !== 64'h1234_5678_9abc_def0) begin fails++; $display("FAIL write_data: got %0h required 123456789abcdef0", imsic_wdata[3]); end
    wait_rsp(cyc, seen, strobes);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL write_latency: got %0d required 2", cyc); end
    tests++; if (seen !== 5'b01000 || strobes !== 1) begin fails++; $display("FAIL write_strobes: mask %b count %0d required 01000 1", seen, strobes); end
    tests++; if (rsp_topei !== 6'd14) begin fails++; $display("FAIL write_topei: got %0d required 14", rsp_topei); end
    tests++; if (rsp_error !== 1'b1) begin fails++; $display("FAIL write_exception: got %0b required 1", rsp_error); end
    ack_rsp();
  endtask

  task automatic test_illegal();
    int            harts [5] = '{5, 0, 7, 1, 1};
    logic [1:0]    privs [5] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    int            vgs   [5] = '{0, 0, 0, 0, 0};
    logic          wes   [5] = '{0, 0, 0, 0, 1};
    logic          cls   [5] = '{0, 0, 0, 0, 1};
    int            cyc;
    logic [NI-1:0] seen;
    int            strobes;
    for (int i = 0; i < 5; i++) begin
      send_req(harts[i], privs[i], vgs[i], 32'h70 + 32'(i), 64'h55, wes[i], cls[i]);
      wait_rsp(cyc, seen, strobes);
      tests++; if (cyc !== 1) begin fails++; $display("FAIL illegal_latency[%0d]: got %0d required 1", i, cyc); end
      tests++; if (seen !== '0) begin fails++; $display("FAIL illegal_no_strobe[%0d]: got %b required 00000", i, seen); end
      tests++; if (rsp_error !== 1'b1) begin fails++; $display("FAIL illegal_error[%0d]: got %0b required 1", i, rsp_error); end
      tests++; if (rsp_data !== '0 || rsp_topei !== '0) begin fails++; $display("FAIL illegal_payload[%0d]: data %0h topei %0d required 0 0", i, rsp_data, rsp_topei); end
      ack_rsp();
    end
  endtask

  task automatic test_back_to_back();
    int harts [6] = '{0, 1, 2, 3, 4, 0};
    int got;
    exp_q = {};
    exp_q.push_back(64'h100);
    exp_q.push_back(64'h101);
    exp_q.push_back(64'hABCD);
    exp_q.push_back(64'h103);
    exp_q.push_back(64'h104);
    exp_q.push_back(64'h100);
    for (int i = 0; i < 5; i++) send_req(harts[i], 2'b11, 0, 32'h80 + 32'(i), '0, 1'b0, 1'b0);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: req_ready %0b required 0", req_ready); end
    tests++; if (dbg_state !== 2'd3) begin fails++; $display("FAIL b2b_fsm_resp: state %0d required 3", dbg_state); end
    req_valid = 1'b1;
    req_hart  = HW'(harts[5]);
    req_priv  = 2'b11;
    req_vgein = '0;
    req_addr  = 32'h85;
    req_data  = '0;
    req_we    = 1'b0;
    req_claim = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall: req_ready %0b required 0", req_ready); end
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h100) begin fails++; $display("FAIL b2b_rsp_hold: valid %0b data %0h required 1 100", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      logic acc;
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_extra_rsp: data %0h with no response outstanding", rsp_data);
        end else if (rsp_data !== exp_q[0]) begin
          fails++; $display("FAIL b2b_order[%0d]: got %0h required %0h", got, rsp_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    tests++; if (got !== 6) begin fails++; $display("FAIL b2b_count: got %0d responses required 6", got); end
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL b2b_sixth_accept: req_valid still %0b required 0", req_valid); end
  endtask

  task automatic test_reset_mid();
    int            seen_cnt;
    int            cyc;
    logic [NI-1:0] seen;
    int            strobes;
    send_req(2, 2'b11, 0, 32'h70, '0, 1'b0, 1'b0);
    send_req(0, 2'b11, 0, 32'h71, '0, 1'b0, 1'b0);
    send_req(1, 2'b11, 0, 32'h72, '0, 1'b0, 1'b0);
    tests++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL rst_mid_in_wait: state %0d required 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rst_mid_state: got %0d required 0", dbg_state); end
    tests++; if (rsp_data !== '0 || rsp_topei !== '0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_rsp_clear: data %0h topei %0d valid %0b required 0 0 0", rsp_data, rsp_topei, rsp_valid); end
    tests++; if (active_mask() !== '0) begin fails++; $display("FAIL rst_mid_imsic: got %b required 00000", active_mask()); end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    seen_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid || active_mask() != '0) seen_cnt++;
      @(posedge clk); #1;
    end
    tests++; if (seen_cnt !== 0) begin fails++; $display("FAIL rst_mid_quiet: %0d active cycles required 0", seen_cnt); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %0b required 1", req_ready); end
    send_req(4, 2'b01, 0, 32'h74, '0, 1'b0, 1'b0);
    wait_rsp(cyc, seen, strobes);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL rst_mid_fresh_latency: got %0d required 3", cyc); end
    tests++; if (seen !== 5'b10000) begin fails++; $display("FAIL rst_mid_fresh_mask: got %b required 10000", seen); end
    tests++; if (rsp_data !== 64'h104 || rsp_topei !== 6'd18) begin fails++; $display("FAIL rst_mid_fresh_rsp: data %0h topei %0d required 104 18", rsp_data, rsp_topei); end
    ack_rsp();
  endtask

  initial begin
    req_valid = 1'b0;
    req_hart  = '0;
    req_priv  = '0;
    req_vgein = '0;
    req_addr  = '0;
    req_data  = '0;
    req_we    = 1'b0;
    req_claim = 1'b0;
    rsp_ready = 1'b0;
    for (int h = 0; h < NI; h++) begin
      imsic_rdata[h] = 64'h100 + 64'(h);
      imsic_exc[h]   = 1'b0;
      for (int f = 0; f < NF; f++) xtopei[h][f] = TW'(h * 4 + f + 1);
    end
    imsic_rdata[2] = 64'hABCD;
    xtopei[2][0]   = 6'd5;
    imsic_exc[3]   = 1'b1;

    test_reset();
    test_read_m();
    test_vs_claim();
    test_write_s();
    test_illegal();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
